uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver, the receiving counterpart of uart_tx; same bit timing, LSB first.
//   Accepts an asynchronous serial line (ftdi/board rx pin) and delivers bytes as 1-cycle strobes to core logic.
//   Samples mid-bit, rejects start-bit glitches, flags framing errors.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); legal range >= 4
//   SYNC_STAGES   2    synchroniser flops on din (2 or 3)
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-high
//   din         in   1  async serial input, idle high
//   data_out    out  8  last good byte; held until next good byte
//   valid       out  1  1-cycle strobe: data_out updated this cycle
//   frame_err   out  1  1-cycle strobe: stop bit sampled low
//   parity_err  out  1  1-cycle strobe: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//   busy        out  1  high from start-bit detection until return to IDLE
// BEHAVIOUR
//   Reset: data_out=8'h00, valid=0, frame_err=0, parity_err=0, busy=0; sync flops=1; state=IDLE.
//   rst wins over everything; a mid-frame reset discards the partial byte, no strobe.
//   din passes SYNC_STAGES flops; all decisions use the synchronised value (rx_s).
//   bit_cnt counts 0..CLKS_PER_BIT-1, clears on every state change; idx 0..7 tracks data bit.
//   IDLE:  rx_s==0 -> START, busy=1.
//   START: at cnt==CLKS_PER_BIT/2-1 (integer divide), sample rx_s: 0 -> DATA; 1 -> IDLE (glitch, no strobe).
//   DATA:  at cnt==CLKS_PER_BIT-1, shift rx_s into shreg[idx] (LSB first); after idx 7 -> STOP
//          (-> PARITY when macro defined).
//   STOP:  at cnt==CLKS_PER_BIT-1 sample rx_s:
//          1 -> data_out<=shreg, valid=1 next cycle, -> IDLE;
//          0 -> frame_err=1, data_out unchanged, -> BREAK.
//   BREAK: wait rx_s==1 -> IDLE (a held-low line yields exactly one frame_err, never a phantom start).
//   Latency: valid rises mid-stop-bit, ~9.5*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after din falls.
//   Strobes never overlap; valid and frame_err mutually exclusive per frame.
//   Back-to-back frames: a start bit immediately after the stop-bit sample point is caught
//   (IDLE re-entered mid-stop-bit).
//   No FIFO/backpressure: consumer must take data_out on valid; next byte overwrites.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     frame is 8E1; PARITY state between DATA and STOP samples 1 bit at CLKS_PER_BIT-1.
//     Mismatch vs even parity of shreg -> parity_err strobe in the stop-sample cycle, no valid,
//     data_out unchanged.
//     If stop is also bad, frame_err takes precedence (parity_err=0).
//   Undefined: 8N1, no PARITY state, parity_err tied 1'b0.
// STRUCTURE
//   uart_pkg:
//     - CLKS_PER_BIT default and baud constants shared with uart_tx
//     - rx state encoding (IDLE, START, DATA, PARITY, STOP, BREAK)
//     - even-parity function
//   Sub-module uart_rx_sync: SYNC_STAGES-deep flop chain, reset value 1, output rx_s.
//   FSM, counters and shift register stay in uart_rx.
// TESTING (bench CLKS_PER_BIT=16 unless noted; drive din via uart_tx with matching CLKS_PER_BIT)
//   1. Send 8'h41 -> one valid strobe, data_out==8'h41, frame_err=0, busy low afterwards.
//   2. 16 back-to-back bytes 8'h00..8'h0F, tx en re-asserted as soon as rdy
//      -> 16 valid strobes in order, none lost.
//   3. din low for 4 clk then high
//      -> no strobe, busy drops within CLKS_PER_BIT/2+SYNC_STAGES+1 cycles, state IDLE.
//   4. Frame 8'hA5 with stop bit forced 0, then din low for 40 bit times
//      -> exactly one frame_err, data_out keeps previous value, next good 8'h3C received correctly.
//   5. rst pulsed during bit 4 of 8'hFF, then 8'h12 sent
//      -> no strobe for 8'hFF, valid with data_out==8'h12.
//   6. With UART_RX_PARITY_EN: 8'h07 with parity bit 0 -> parity_err, no valid;
//      with parity bit 1 -> valid, data_out==8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and parity helper.
// Used by uart_rx (and its transmit counterpart uart_tx).
package uart_pkg;

  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned BAUD             = 115_200;
  localparam int unsigned CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser chain for the asynchronous serial input; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic rx_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error strobe.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMid = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntEnd = CntW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .din_i (din),
    .rx_s_o(rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntMid) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntEnd) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntEnd) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntEnd) begin
          cnt_d = '0;
          if (rx_s) begin
            // Back to IDLE mid-stop-bit so an immediately following start bit is caught.
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_q != even_parity(shreg_q)) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shreg_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);

endmodule
